// File: rtl/id_pkg.sv
// -----------------------------------------------------------------------------
// id_pkg
// Shared definitions for the ID hazard stage: decoded-control struct, operand
// forwarding select encodings, hazard-stage FSM states and the bubble (NOP)
// control word.
// Build option: ID_FORWARD_EN (see hazard_unit) changes behaviour only, not
// anything declared here.
// -----------------------------------------------------------------------------
package id_pkg;

    // Decoded control word produced by the ID control unit (20 bits total).
    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
        logic [2:0] imm_sel;
        logic [1:0] wb_sel;
        logic [3:0] rsvd;
    } ctrl_t;

    // All-zero control: no register write, no memory access.
    localparam ctrl_t CTRL_NOP = '0;

    // Operand source selects presented to EX.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MUL_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/id_hazard_stage_hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
// Combinational RAW detection between the instruction in ID and the writers in
// EX and MEM. Produces a stall request and per-operand forwarding selects.
// Build option: ID_FORWARD_EN
//   defined   : only a load in EX feeding ID stalls; other matches forward,
//               EX has priority over MEM.
//   undefined : any EX/MEM match stalls; forwarding selects are tied to FWD_RF.
// Ports:
//   use_rs1_i/use_rs2_i, rs1_i/rs2_i : ID source usage and specifiers
//   ex_rd_i, ex_regwrite_i, ex_load_i: writer in EX
//   mem_rd_i, mem_regwrite_i         : writer in MEM
//   hazard_o                         : ID must not advance this cycle
//   fwd_a_o, fwd_b_o                 : operand source selects
// -----------------------------------------------------------------------------
module hazard_unit
    import id_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  use_rs1_i,
    input  logic                  use_rs2_i,
    input  logic [REG_ADDR_W-1:0] rs1_i,
    input  logic [REG_ADDR_W-1:0] rs2_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_regwrite_i,
    input  logic                  ex_load_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic                  mem_regwrite_i,
    output logic                  hazard_o,
    output logic [1:0]            fwd_a_o,
    output logic [1:0]            fwd_b_o
);

    logic ex_m1, ex_m2, mem_m1, mem_m2, load_use;

    // r0 is hard-wired zero, so it never creates a dependency.
    assign ex_m1  = use_rs1_i && (rs1_i != '0) && ex_regwrite_i  && (rs1_i == ex_rd_i);
    assign ex_m2  = use_rs2_i && (rs2_i != '0) && ex_regwrite_i  && (rs2_i == ex_rd_i);
    assign mem_m1 = use_rs1_i && (rs1_i != '0) && mem_regwrite_i && (rs1_i == mem_rd_i);
    assign mem_m2 = use_rs2_i && (rs2_i != '0) && mem_regwrite_i && (rs2_i == mem_rd_i);

    assign load_use = ex_load_i && (ex_m1 || ex_m2);

`ifdef ID_FORWARD_EN
    assign hazard_o = load_use;
    assign fwd_a_o  = ex_m1 ? FWD_EX : (mem_m1 ? FWD_MEM : FWD_RF);
    assign fwd_b_o  = ex_m2 ? FWD_EX : (mem_m2 ? FWD_MEM : FWD_RF);
`else
    // load_use is a subset of the EX matches; OR-ing it in is logically redundant.
    assign hazard_o = load_use || ex_m1 || ex_m2 || mem_m1 || mem_m2;
    assign fwd_a_o  = FWD_RF;
    assign fwd_b_o  = FWD_RF;
`endif

endmodule

// File: rtl/id_hazard_stage.sv
// -----------------------------------------------------------------------------
// id_hazard_stage
// ID/EX pipeline register with RAW hazard stalls, branch flush squashing and a
// multi-cycle multiply occupancy wait.
//
//   state       | meaning
//   ------------+----------------------------------------------------------
//   ST_RUN      | ID/EX loads each cycle (instruction or bubble)
//   ST_MUL_WAIT | multiply holds EX; ID/EX and front end frozen, counter runs
//
// Build option: ID_FORWARD_EN enables operand forwarding (see hazard_unit).
// Ports:
//   clk, reset (async, active-high)
//   valid_in, nextPC_in, busA_in, busB_in, ctrl_in, rs*/rd_in, use_rs*, is_mul
//                : instruction in IF/ID
//   ex_*, mem_*  : downstream writer info
//   flush        : taken branch/jump squashes ID
//   stall_out    : hold PC and IF/ID
//   valid_out, nextPC_out, busA_out, busB_out, ctrl_out, rd_out, fwdA_sel,
//   fwdB_sel     : ID/EX register contents
//   mul_busy     : multiply occupying EX
// -----------------------------------------------------------------------------
module id_hazard_stage
    import id_pkg::*;
#(
    parameter int SIZE       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 20,
    parameter int MUL_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [SIZE-1:0]       nextPC_in,
    input  logic [SIZE-1:0]       busA_in,
    input  logic [SIZE-1:0]       busB_in,
    input  logic [CTRL_W-1:0]     ctrl_in,
    input  logic [REG_ADDR_W-1:0] rs1_in,
    input  logic [REG_ADDR_W-1:0] rs2_in,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic                  use_rs1,
    input  logic                  use_rs2,
    input  logic                  is_mul,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  ex_regwrite,
    input  logic                  ex_load,
    input  logic                  mem_regwrite,
    input  logic                  flush,
    output logic                  stall_out,
    output logic                  valid_out,
    output logic [SIZE-1:0]       nextPC_out,
    output logic [SIZE-1:0]       busA_out,
    output logic [SIZE-1:0]       busB_out,
    output logic [CTRL_W-1:0]     ctrl_out,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic [1:0]            fwdA_sel,
    output logic [1:0]            fwdB_sel,
    output logic                  mul_busy
);

    localparam logic [3:0] MUL_INIT = 4'(MUL_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       pend_q, pend_d;
    logic       load, bubble, stall_int, hazard;
    logic [1:0] fwd_a, fwd_b;

    hazard_unit #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
        .use_rs1_i      (use_rs1),
        .use_rs2_i      (use_rs2),
        .rs1_i          (rs1_in),
        .rs2_i          (rs2_in),
        .ex_rd_i        (ex_rd),
        .ex_regwrite_i  (ex_regwrite),
        .ex_load_i      (ex_load),
        .mem_rd_i       (mem_rd),
        .mem_regwrite_i (mem_regwrite),
        .hazard_o       (hazard),
        .fwd_a_o        (fwd_a),
        .fwd_b_o        (fwd_b)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        load      = 1'b0;
        bubble    = 1'b0;
        stall_int = 1'b0;
        case (state_q)
            ST_RUN: begin
                // A flush seen during the multiply wait squashes the
                // instruction that was parked in IF/ID, exactly like a live flush.
                if (flush || pend_q) begin
                    bubble = 1'b1;
                    pend_d = 1'b0;
                end else if (!valid_in) begin
                    bubble = 1'b1;
                end else if (hazard) begin
                    bubble    = 1'b1;
                    stall_int = 1'b1;
                end else begin
                    load = 1'b1;
                    if (is_mul) begin
                        state_d = ST_MUL_WAIT;
                        cnt_d   = MUL_INIT;
                    end
                end
            end
            ST_MUL_WAIT: begin
                stall_int = 1'b1;
                cnt_d     = cnt_q - 4'd1;
                if (flush) pend_d = 1'b1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            valid_out  <= 1'b0;
            nextPC_out <= '0;
            busA_out   <= '0;
            busB_out   <= '0;
            ctrl_out   <= '0;
            rd_out     <= '0;
            fwdA_sel   <= FWD_RF;
            fwdB_sel   <= FWD_RF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            if (load) begin
                valid_out  <= 1'b1;
                nextPC_out <= nextPC_in;
                busA_out   <= busA_in;
                busB_out   <= busB_in;
                ctrl_out   <= ctrl_in;
                rd_out     <= rd_in;
                fwdA_sel   <= fwd_a;
                fwdB_sel   <= fwd_b;
            end else if (bubble) begin
                // Data buses are don't-care in a bubble; leaving them avoids toggling.
                valid_out <= 1'b0;
                ctrl_out  <= CTRL_W'(CTRL_NOP);
                rd_out    <= '0;
                fwdA_sel  <= FWD_RF;
                fwdB_sel  <= FWD_RF;
            end
        end
    end

    // Gated by reset so an abort mid-multiply releases the front end at once.
    assign stall_out = stall_int && !reset;
    assign mul_busy  = (state_q == ST_MUL_WAIT) && !reset;

endmodule

// File: tb/tb_id_hazard_stage.sv
module tb_id_hazard_stage;
    import id_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [31:0] nextPC_in, busA_in, busB_in;
    logic [19:0] ctrl_in;
    logic [4:0]  rs1_in, rs2_in, rd_in;
    logic        use_rs1, use_rs2, is_mul;
    logic [4:0]  ex_rd, mem_rd;
    logic        ex_regwrite, ex_load, mem_regwrite, flush;
    logic        stall_out, valid_out, mul_busy;
    logic [31:0] nextPC_out, busA_out, busB_out;
    logic [19:0] ctrl_out;
    logic [4:0]  rd_out;
    logic [1:0]  fwdA_sel, fwdB_sel;

    id_hazard_stage dut (
        .clk(clk), .reset(reset), .valid_in(valid_in),
        .nextPC_in(nextPC_in), .busA_in(busA_in), .busB_in(busB_in),
        .ctrl_in(ctrl_in), .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in),
        .use_rs1(use_rs1), .use_rs2(use_rs2), .is_mul(is_mul),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .ex_regwrite(ex_regwrite),
        .ex_load(ex_load), .mem_regwrite(mem_regwrite), .flush(flush),
        .stall_out(stall_out), .valid_out(valid_out), .nextPC_out(nextPC_out),
        .busA_out(busA_out), .busB_out(busB_out), .ctrl_out(ctrl_out),
        .rd_out(rd_out), .fwdA_sel(fwdA_sel), .fwdB_sel(fwdB_sel),
        .mul_busy(mul_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    due;
        string nm;
        logic  stall;
        logic  busy;
    } comb_t;

    typedef struct {
        int          due;
        string       nm;
        logic        v;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [1:0]  fa;
        logic [1:0]  fb;
    } reg_t;

    comb_t cq[$];
    reg_t  rq[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: compares whatever the scoreboard says is due this cycle.
    always @(negedge clk) begin : mon
        comb_t c;
        reg_t  r;
        if (!reset) begin
            if (cq.size() > 0 && cq[0].due == cyc) begin
                c = cq.pop_front();
                chk({c.nm, ".stall_out"}, 32'(stall_out), 32'(c.stall));
                chk({c.nm, ".mul_busy"},  32'(mul_busy),  32'(c.busy));
            end
            if (rq.size() > 0 && rq[0].due == cyc) begin
                r = rq.pop_front();
                chk({r.nm, ".valid_out"}, 32'(valid_out), 32'(r.v));
                chk({r.nm, ".rd_out"},    32'(rd_out),    32'(r.rd));
                chk({r.nm, ".ctrl_out"},  32'(ctrl_out),  r.v ? 32'(20'(r.pc)) : 32'd0);
                chk({r.nm, ".fwdA_sel"},  32'(fwdA_sel),  32'(r.fa));
                chk({r.nm, ".fwdB_sel"},  32'(fwdB_sel),  32'(r.fb));
                if (r.v) begin
                    chk({r.nm, ".nextPC_out"}, nextPC_out, r.pc);
                    chk({r.nm, ".busA_out"},   busA_out,   r.pc + 32'd1);
                    chk({r.nm, ".busB_out"},   busB_out,   r.pc + 32'd2);
                end
            end
        end
    end

    task automatic writers_clear();
        ex_rd = 0; mem_rd = 0; ex_regwrite = 0; ex_load = 0; mem_regwrite = 0;
    endtask

    task automatic instr(input int tag, input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2,
                         input logic [4:0] rd, input logic mul);
        valid_in = 1; nextPC_in = tag; busA_in = tag + 1; busB_in = tag + 2;
        ctrl_in = 20'(tag); rs1_in = r1; use_rs1 = u1; rs2_in = r2; use_rs2 = u2;
        rd_in = rd; is_mul = mul;
    endtask

    // Push expectations for the inputs now applied, then advance one cycle.
    task automatic step(input string nm, input logic es, input logic eb,
                        input logic chk_r, input logic ev, input logic [4:0] erd,
                        input int epc, input logic [1:0] efa, input logic [1:0] efb);
        comb_t c;
        reg_t  r;
        c.due = cyc; c.nm = nm; c.stall = es; c.busy = eb;
        cq.push_back(c);
        if (chk_r) begin
            r.due = cyc + 1; r.nm = nm; r.v = ev; r.rd = erd; r.pc = epc;
            r.fa = efa; r.fb = efb;
            rq.push_back(r);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_zero(input string nm);
        chk({nm, ".stall_out"},  32'(stall_out), 0);
        chk({nm, ".mul_busy"},   32'(mul_busy),  0);
        chk({nm, ".valid_out"},  32'(valid_out), 0);
        chk({nm, ".ctrl_out"},   32'(ctrl_out),  0);
        chk({nm, ".rd_out"},     32'(rd_out),    0);
        chk({nm, ".nextPC_out"}, nextPC_out,     0);
        chk({nm, ".busA_out"},   busA_out,       0);
        chk({nm, ".busB_out"},   busB_out,       0);
        chk({nm, ".fwd_sel"},    32'({fwdA_sel, fwdB_sel}), 0);
    endtask

    initial begin
        reset = 1; flush = 0;
        writers_clear();
        // Hazard present while in reset: must not stall.
        instr(50, 5'd1, 1, 0, 0, 5'd2, 1);
        ex_regwrite = 1; ex_rd = 5'd1;
        #1 check_zero("reset");
        repeat (3) @(posedge clk);
        #1 reset = 0;
        writers_clear();

        instr(100, 5'd1, 1, 0, 0, 5'd7, 0);
        step("plain", 0, 0, 1, 1, 5'd7, 100, 0, 0);

        ex_regwrite = 1; ex_rd = 0;
        instr(200, 5'd0, 1, 0, 0, 5'd8, 0);
        step("r0_no_raw", 0, 0, 1, 1, 5'd8, 200, 0, 0);

        ex_rd = 5'd3;
        instr(300, 5'd3, 1, 0, 0, 5'd9, 0);
`ifdef ID_FORWARD_EN
        step("raw_ex", 0, 0, 1, 1, 5'd9, 300, 2'b01, 0);
`else
        step("raw_ex", 1, 0, 1, 0, 0, 0, 0, 0);
`endif
        writers_clear();
        step("raw_ex_after", 0, 0, 1, 1, 5'd9, 300, 0, 0);

        ex_regwrite = 1; ex_load = 1; ex_rd = 5'd5;
        instr(400, 0, 0, 5'd5, 1, 5'd10, 0);
        step("load_use", 1, 0, 1, 0, 0, 0, 0, 0);
        writers_clear();
        mem_regwrite = 1; mem_rd = 5'd5;
`ifdef ID_FORWARD_EN
        step("load_use_next", 0, 0, 1, 1, 5'd10, 400, 0, 2'b10);
`else
        step("load_use_next", 1, 0, 1, 0, 0, 0, 0, 0);
`endif
        writers_clear();
        step("load_use_done", 0, 0, 1, 1, 5'd10, 400, 0, 0);

        ex_regwrite = 1; ex_rd = 5'd6; mem_regwrite = 1; mem_rd = 5'd6;
        instr(500, 5'd6, 1, 5'd6, 1, 5'd11, 0);
`ifdef ID_FORWARD_EN
        step("ex_over_mem", 0, 0, 1, 1, 5'd11, 500, 2'b01, 2'b01);
`else
        step("ex_over_mem", 1, 0, 1, 0, 0, 0, 0, 0);
`endif
        writers_clear();
        step("ex_over_mem_done", 0, 0, 1, 1, 5'd11, 500, 0, 0);

        ex_regwrite = 1; ex_rd = 5'd2;
        instr(600, 5'd2, 0, 0, 0, 5'd12, 0);
        step("unused_rs", 0, 0, 1, 1, 5'd12, 600, 0, 0);
        writers_clear();

        instr(700, 0, 0, 0, 0, 5'd13, 1);
        step("mul_load", 0, 0, 1, 1, 5'd13, 700, 0, 0);
        instr(800, 0, 0, 0, 0, 5'd14, 0);
        step("mul_w1", 1, 1, 1, 1, 5'd13, 700, 0, 0);
        flush = 1;
        step("mul_w2_flush", 1, 1, 1, 1, 5'd13, 700, 0, 0);
        flush = 0;
        step("mul_w3", 1, 1, 1, 1, 5'd13, 700, 0, 0);
        step("pend_bubble", 0, 0, 1, 0, 0, 0, 0, 0);
        step("after_pend", 0, 0, 1, 1, 5'd14, 800, 0, 0);

        ex_regwrite = 1; ex_rd = 5'd3; flush = 1;
        instr(900, 5'd3, 1, 0, 0, 5'd15, 1);
        step("flush_run", 0, 0, 1, 0, 0, 0, 0, 0);
        flush = 0; writers_clear();
        instr(1000, 0, 0, 0, 0, 5'd16, 0);
        step("post_flush", 0, 0, 1, 1, 5'd16, 1000, 0, 0);

        ex_regwrite = 1; ex_load = 1; ex_rd = 5'd4;
        instr(1100, 5'd4, 1, 0, 0, 5'd17, 1);
        step("hazard_mul", 1, 0, 1, 0, 0, 0, 0, 0);
        writers_clear();
        step("mul2_load", 0, 0, 1, 1, 5'd17, 1100, 0, 0);
        instr(1200, 0, 0, 0, 0, 5'd18, 0);
        step("mul2_w1", 1, 1, 1, 1, 5'd17, 1100, 0, 0);
        step("mul2_w2", 1, 1, 0, 0, 0, 0, 0, 0);

        // Still in the multiply wait: abort with reset, hazard on the inputs.
        ex_regwrite = 1; ex_rd = 5'd1;
        instr(1200, 5'd1, 1, 0, 0, 5'd18, 0);
        reset = 1;
        #1 check_zero("reset_mid_mul");
        @(posedge clk); #1 check_zero("reset_hold");
        @(posedge clk); #1 reset = 0;
        writers_clear();
        step("post_reset", 0, 0, 1, 1, 5'd18, 1200, 0, 0);
        valid_in = 0;
        step("idle", 0, 0, 1, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && (cq.size() + rq.size()) > 0; i++) @(posedge clk);
        #1;
        checks++;
        if ((cq.size() + rq.size()) != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", cq.size() + rq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
